// File: rtl/uart_field_parser.sv
// ASCII-decimal frame parser: NUM_FIELDS fields of DIGITS digits each, committed atomically.
// Optional inter-byte timeout enabled by defining UART_FIELD_PARSER_TIMEOUT_EN.
module uart_field_parser #(
  parameter int unsigned NUM_FIELDS  = 4,
  parameter int unsigned DIGITS      = 3,
  parameter int unsigned FIELD_W     = 10,
  parameter int unsigned TIMEOUT_CYC = 520800
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [7:0]                    pi_data,
  input  logic                          pi_flag,
  output logic [NUM_FIELDS*FIELD_W-1:0] po_fields,
  output logic                          po_valid,
  output logic                          po_err,
  output logic                          po_busy
);

  localparam int unsigned AccW = FIELD_W + 4;
  localparam int unsigned DigW = $clog2(DIGITS + 1);
  localparam int unsigned IdxW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [AccW-1:0] MaxVal = {4'b0000, {FIELD_W{1'b1}}};

  typedef enum logic {StIdle, StRecv} state_e;

  state_e                          state_q, state_d;
  logic [AccW-1:0]                 acc_q, acc_d;
  logic                            sat_q, sat_d;
  logic [DigW-1:0]                 digit_cnt_q, digit_cnt_d;
  logic [IdxW-1:0]                 field_idx_q, field_idx_d;
  logic [NUM_FIELDS*FIELD_W-1:0]   shadow_q, shadow_d;
  logic [NUM_FIELDS*FIELD_W-1:0]   fields_q, fields_d;
  logic                            valid_q, valid_d;
  logic                            err_q, err_d;

  logic                            is_digit;
  logic [AccW-1:0]                 acc_next;
  logic                            sat_next;
  logic [FIELD_W-1:0]              field_val;
  logic                            last_digit;
  logic                            last_field;
  logic                            abort;

  assign is_digit   = (pi_data >= 8'h30) && (pi_data <= 8'h39);
  // acc never exceeds MaxVal here, so acc*10+9 always fits in AccW bits
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + {{(AccW-4){1'b0}}, pi_data[3:0]};
  assign sat_next   = sat_q | (acc_next > MaxVal);
  assign field_val  = sat_next ? MaxVal[FIELD_W-1:0] : acc_next[FIELD_W-1:0];
  assign last_digit = (digit_cnt_q == DigW'(DIGITS - 1));
  assign last_field = (field_idx_q == IdxW'(NUM_FIELDS - 1));

`ifdef UART_FIELD_PARSER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_expire;

  assign tmo_expire = (state_q == StRecv) && !pi_flag && (tmo_q == TmoW'(TIMEOUT_CYC - 1));
  assign tmo_d      = ((state_q == StRecv) && !pi_flag && !abort) ? tmo_q + 1'b1 : '0;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  logic tmo_expire;
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sat_d       = sat_q;
    digit_cnt_d = digit_cnt_q;
    field_idx_d = field_idx_q;
    shadow_d    = shadow_q;
    fields_d    = fields_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    abort       = 1'b0;

    if (pi_flag) begin
      if (is_digit) begin
        state_d     = StRecv;
        sat_d       = sat_next;
        digit_cnt_d = digit_cnt_q + 1'b1;
        if (!sat_next) acc_d = acc_next;
        if (last_digit) begin
          shadow_d[int'(field_idx_q)*FIELD_W +: FIELD_W] = field_val;
          acc_d       = '0;
          sat_d       = 1'b0;
          digit_cnt_d = '0;
          field_idx_d = field_idx_q + 1'b1;
          if (last_field) begin
            // Commit the full shadow including the field just written
            fields_d    = shadow_d;
            shadow_d    = '0;
            field_idx_d = '0;
            valid_d     = 1'b1;
            state_d     = StIdle;
          end
        end
      end else if (state_q == StRecv) begin
        abort = 1'b1;
      end
    end else if (tmo_expire) begin
      abort = 1'b1;
    end

    if (abort) begin
      state_d     = StIdle;
      acc_d       = '0;
      sat_d       = 1'b0;
      digit_cnt_d = '0;
      field_idx_d = '0;
      shadow_d    = '0;
      err_d       = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      digit_cnt_q <= '0;
      field_idx_q <= '0;
      shadow_q    <= '0;
      fields_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      digit_cnt_q <= digit_cnt_d;
      field_idx_q <= field_idx_d;
      shadow_q    <= shadow_d;
      fields_q    <= fields_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign po_fields = fields_q;
  assign po_valid  = valid_q;
  assign po_err    = err_q;
  assign po_busy   = (state_q == StRecv);

endmodule

// File: tb/tb_uart_field_parser.sv
// Bench for uart_field_parser: default instance plus an 8-bit single-field instance.
// Timeout sequence depends on UART_FIELD_PARSER_TIMEOUT_EN.
module tb_uart_field_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pi_data = 8'h00;
  logic        flag_a = 1'b0;
  logic        flag_b = 1'b0;

  logic [39:0] fields_a;
  logic        valid_a, err_a, busy_a;
  logic [7:0]  fields_b;
  logic        valid_b, err_b, busy_b;

  always #10 clk = ~clk;

  uart_field_parser #(
    .NUM_FIELDS (4),
    .DIGITS     (3),
    .FIELD_W    (10),
    .TIMEOUT_CYC(100)
  ) dut_a (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .pi_data  (pi_data),
    .pi_flag  (flag_a),
    .po_fields(fields_a),
    .po_valid (valid_a),
    .po_err   (err_a),
    .po_busy  (busy_a)
  );

  uart_field_parser #(
    .NUM_FIELDS (1),
    .DIGITS     (3),
    .FIELD_W    (8),
    .TIMEOUT_CYC(100)
  ) dut_b (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .pi_data  (pi_data),
    .pi_flag  (flag_b),
    .po_fields(fields_b),
    .po_valid (valid_b),
    .po_err   (err_b),
    .po_busy  (busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse monitor: counts pulses and flags overlap or pulses wider than one cycle
  int  vcnt_a = 0, ecnt_a = 0, vcnt_b = 0, ecnt_b = 0;
  int  overlap = 0, wide = 0;
  bit  pv_a = 0, pe_a = 0, pv_b = 0, pe_b = 0;
  always @(negedge clk) begin
    if (valid_a) vcnt_a++;
    if (err_a)   ecnt_a++;
    if (valid_b) vcnt_b++;
    if (err_b)   ecnt_b++;
    if ((valid_a && err_a) || (valid_b && err_b)) overlap++;
    if ((valid_a && pv_a) || (err_a && pe_a) || (valid_b && pv_b) || (err_b && pe_b)) wide++;
    pv_a = valid_a; pe_a = err_a; pv_b = valid_b; pe_b = err_b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit tgt_b);
    pi_data = b;
    if (tgt_b) flag_b = 1'b1;
    else       flag_a = 1'b1;
    @(posedge clk);
    #1;
    flag_a = 1'b0;
    flag_b = 1'b0;
  endtask

  task automatic send_str(input logic [8*14-1:0] t, input int len, input int gap,
                          input bit tgt_b);
    for (int j = 0; j < len; j++) begin
      send_byte(t[8*(len-1-j) +: 8], tgt_b);
      if (gap > 0 && j < len - 1) tick(gap);
    end
  endtask

  function automatic logic [39:0] pack4(input int f0, input int f1, input int f2, input int f3);
    return {10'(f3), 10'(f2), 10'(f1), 10'(f0)};
  endfunction

  typedef struct {
    logic [8*14-1:0] text;
    int              len;
    int              gap;
    bit              tgt_b;
    int              exp_v;
    int              exp_e;
    logic [39:0]     exp_f;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int v0, e0, hit;

    vecs[0] = '{"640480001234",   12, 9, 1'b0, 1, 0, pack4(640, 480, 1, 234)};
    vecs[1] = '{"640480x",         7, 0, 1'b0, 0, 1, pack4(640, 480, 1, 234)};
    vecs[2] = '{"123456789012",   12, 0, 1'b0, 1, 0, pack4(123, 456, 789, 12)};
    vecs[3] = '{"\r\n999000500010", 14, 0, 1'b0, 1, 0, pack4(999, 0, 500, 10)};
    vecs[4] = '{"300",             3, 0, 1'b1, 1, 0, 40'd255};
    vecs[5] = '{"255",             3, 2, 1'b1, 1, 0, 40'd255};
    vecs[6] = '{"099",             3, 0, 1'b1, 1, 0, 40'd99};

    // Reset state
    tick(2);
    check("rst_fields_a", fields_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_err_a", err_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_fields_b", fields_b, 0);
    rst = 1'b0;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      v0 = vecs[i].tgt_b ? vcnt_b : vcnt_a;
      e0 = vecs[i].tgt_b ? ecnt_b : ecnt_a;
      send_str(vecs[i].text, vecs[i].len, vecs[i].gap, vecs[i].tgt_b);
      // One cycle after the final byte's strobe
      check($sformatf("v%0d_lat_valid", i), vecs[i].tgt_b ? valid_b : valid_a,
            64'(vecs[i].exp_v != 0));
      check($sformatf("v%0d_lat_err", i), vecs[i].tgt_b ? err_b : err_a,
            64'(vecs[i].exp_e != 0));
      tick(3);
      check($sformatf("v%0d_nvalid", i), (vecs[i].tgt_b ? vcnt_b : vcnt_a) - v0,
            64'(vecs[i].exp_v));
      check($sformatf("v%0d_nerr", i), (vecs[i].tgt_b ? ecnt_b : ecnt_a) - e0,
            64'(vecs[i].exp_e));
      if (vecs[i].tgt_b) check($sformatf("v%0d_fields", i), fields_b, vecs[i].exp_f[7:0]);
      else               check($sformatf("v%0d_fields", i), fields_a, vecs[i].exp_f);
      check($sformatf("v%0d_busy", i), vecs[i].tgt_b ? busy_b : busy_a, 0);
    end

    // Back-to-back frames: new frame's first digit in the cycle after commit
    v0 = vcnt_a;
    send_str("111222333444", 12, 0, 1'b0);
    check("b2b_first_fields", fields_a, pack4(111, 222, 333, 444));
    send_str("555666777888", 12, 0, 1'b0);
    tick(2);
    check("b2b_nvalid", vcnt_a - v0, 2);
    check("b2b_fields", fields_a, pack4(555, 666, 777, 888));

    // Reset mid-frame
    e0 = ecnt_a;
    v0 = vcnt_a;
    send_str("12345", 5, 0, 1'b0);
    check("mid_busy", busy_a, 1);
    rst = 1'b1;
    tick(2);
    check("mid_rst_fields", fields_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_err", err_a, 0);
    rst = 1'b0;
    tick(1);
    check("mid_rst_nopulse", (vcnt_a - v0) + (ecnt_a - e0), 0);
    send_str("000000000007", 12, 0, 1'b0);
    tick(2);
    check("mid_after_fields", fields_a, pack4(0, 0, 0, 7));

    // Inter-byte timeout
    e0 = ecnt_a;
    v0 = vcnt_a;
    send_str("64", 2, 0, 1'b0);
`ifdef UART_FIELD_PARSER_TIMEOUT_EN
    hit = -1;
    for (int c = 1; c <= 150; c++) begin
      tick(1);
      if (hit < 0 && err_a) hit = c;
    end
    check("tmo_seen", 64'(hit > 0), 1);
    check("tmo_window", 64'(hit >= 98 && hit <= 102), 1);
    check("tmo_nerr", ecnt_a - e0, 1);
    check("tmo_busy", busy_a, 0);
    check("tmo_fields_kept", fields_a, pack4(0, 0, 0, 7));
    send_str("640480001234", 12, 0, 1'b0);
`else
    hit = 0;
    tick(150);
    check("hold_nerr", ecnt_a - e0, 0);
    check("hold_busy", busy_a, 1);
    send_str("0480001234", 10, 0, 1'b0);
`endif
    tick(2);
    check("tmo_after_nvalid", vcnt_a - v0, 1);
    check("tmo_after_fields", fields_a, pack4(640, 480, 1, 234));

    check("pulse_overlap", overlap, 0);
    check("pulse_width", wide, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
